mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the data word width.
REQ-002 The block SHALL have parameter RAM_WIDTH, default 31, giving the RAM address width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 3, giving the number of consecutive fetch denials before fetch is forced.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port if_req, input, 1 bit: instruction fetch read request.
REQ-007 The block SHALL have port if_addr, input, RAM_WIDTH bits: fetch address.
REQ-008 The block SHALL have port if_gnt, output, 1 bit: fetch accepted this cycle.
REQ-009 The block SHALL have port if_rvalid, output, 1 bit: if_rdata valid.
REQ-010 The block SHALL have port if_rdata, output, DATA_WIDTH bits: fetched word.
REQ-011 The block SHALL have port dm_req, input, 1 bit: data access request.
REQ-012 The block SHALL have port dm_we, input, 1 bit: 1 = store, 0 = load.
REQ-013 The block SHALL have port dm_addr, input, RAM_WIDTH bits: data address.
REQ-014 The block SHALL have port dm_wdata, input, DATA_WIDTH bits: store data.
REQ-015 The block SHALL have port dm_gnt, output, 1 bit: data access accepted this cycle.
REQ-016 The block SHALL have port dm_rvalid, output, 1 bit: dm_rdata valid.
REQ-017 The block SHALL have port dm_rdata, output, DATA_WIDTH bits: loaded word.
REQ-018 The block SHALL have port ram_address, output, RAM_WIDTH bits: RAM address.
REQ-019 The block SHALL have port ram_re, output, 1 bit: RAM read strobe.
REQ-020 The block SHALL have port ram_we, output, 1 bit: RAM write strobe.
REQ-021 The block SHALL have port ram_wdata, output, DATA_WIDTH bits: RAM write data.
REQ-022 The block SHALL have port ram_rdata, input, DATA_WIDTH bits: RAM read data, valid the cycle after ram_re.

Function
REQ-023 At most one of if_gnt and dm_gnt SHALL be high in any cycle, and each grant SHALL be combinational from the current-cycle requests and registered state.
REQ-024 When only one requester is asserting, that requester SHALL be granted.
REQ-025 On contention, dm SHALL win unless starve_cnt == STARVE_LIMIT, in which case if SHALL win.
REQ-026 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each cycle with if_req high and if_gnt low, and SHALL clear on if_gnt or when if_req is low.
REQ-027 In a granted cycle, ram_address SHALL equal the winner's address.
REQ-028 In a granted cycle, ram_re SHALL equal 1 for a fetch or a load, and ram_we SHALL equal 1 for a store.
REQ-029 In a granted store cycle, ram_wdata SHALL equal dm_wdata.
REQ-030 In an ungranted cycle, ram_re, ram_we, ram_address and ram_wdata SHALL all be 0.
REQ-031 A read granted in cycle N SHALL assert exactly one of if_rvalid/dm_rvalid in cycle N+1, for one cycle, routed by a registered owner tag.
REQ-032 During the cycle in which its rvalid is asserted, the corresponding rdata output SHALL equal ram_rdata; both rdata outputs SHALL be 0 in all other cycles.
REQ-033 A store SHALL complete in its grant cycle and SHALL produce no rvalid.
REQ-034 Back-to-back grants SHALL be allowed every cycle; a return in cycle N+1 SHALL coexist with a new grant in cycle N+1.
REQ-035 Requesters SHALL hold req, addr, we and wdata stable until granted; the block SHALL NOT buffer ungranted requests.

Reset
REQ-036 While rst_n is low, all outputs, starve_cnt and the owner tag SHALL be 0 immediately, independent of clk.
REQ-037 A read granted in the cycle before reset assertion SHALL produce no rvalid after reset release.
REQ-038 The first rising clk edge after rst_n goes high SHALL be able to grant.

Verification
REQ-039 The bench SHALL cover: if_req only, if_addr=0x10, ram_rdata=0xDEADBEEF next cycle -> if_gnt in cycle 0, if_rvalid with if_rdata=0xDEADBEEF in cycle 1, dm_rvalid=0.
REQ-040 The bench SHALL cover: dm store, dm_addr=0x20, dm_wdata=0x12345678 -> ram_we=1, ram_address=0x20, ram_wdata=0x12345678 in the same cycle, no rvalid in the next cycle.
REQ-041 The bench SHALL cover: if_req and dm_req held high for 8 cycles with dm loads and STARVE_LIMIT=3 -> grants dm,dm,dm,if,dm,dm,dm,if.
REQ-042 The bench SHALL cover: alternating dm load and fetch granted in consecutive cycles -> each rvalid one cycle after its grant, routed correctly, with no overlap on either port.
REQ-043 The bench SHALL cover: rst_n driven low mid-cycle right after a load grant -> all outputs 0 at once, no dm_rvalid after release.
REQ-044 The bench SHALL cover: no requests -> ram_re=ram_we=0 and both gnt=0 every cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the RAM and mem_arbiter.
//   slave  : the arbiter side (takes requests and RAM read data, drives the
//            grants, returns and RAM strobes)
//   master : the environment side (requesters plus the RAM itself)
// Signals:
//   if_req/if_addr -> if_gnt, if_rvalid, if_rdata        instruction fetch
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_gnt, dm_rvalid, dm_rdata   data port
//   ram_address, ram_re, ram_we, ram_wdata -> RAM; ram_rdata <- RAM
//   (ram_rdata is valid the cycle after ram_re)
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_WIDTH  = 31
);
  logic                  if_req;
  logic [RAM_WIDTH-1:0]  if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [RAM_WIDTH-1:0]  dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;

  logic [RAM_WIDTH-1:0]  ram_address;
  logic                  ram_re;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           ram_address, ram_re, ram_we, ram_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           ram_address, ram_re, ram_we, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester single-port RAM arbiter. The data port wins contention
// unless the fetch port has been denied STARVE_LIMIT consecutive cycles.
// Grants and RAM strobes are combinational from the current requests;
// read data returns one cycle later, routed by a registered owner tag.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mem_arbiter_if.slave (requests, grants, returns, RAM side)
module mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int RAM_WIDTH    = 31,
  parameter int STARVE_LIMIT = 3
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  localparam int             CW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } owner_e;

  owner_e                owner, owner_nxt;
  logic [CW-1:0]         starve_cnt, starve_nxt;
  logic                  if_win, dm_win;
  logic [RAM_WIDTH-1:0]  addr_mux;
  logic [DATA_WIDTH-1:0] wdata_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    if_win     = 1'b0;
    dm_win     = 1'b0;
    addr_mux   = '0;
    wdata_mux  = '0;
    owner_nxt  = OWN_NONE;
    starve_nxt = '0;
    // Grants are masked while in reset so every output drops immediately.
    if (rst_n) begin
      if_win = bus.if_req && (!bus.dm_req || starve_cnt == LIMIT);
      dm_win = bus.dm_req && !if_win;
    end
    if (if_win) begin
      addr_mux  = bus.if_addr;
      owner_nxt = OWN_IF;
    end else if (dm_win) begin
      addr_mux = bus.dm_addr;
      if (bus.dm_we) begin
        wdata_mux = bus.dm_wdata;
      end else begin
        owner_nxt = OWN_DM;
      end
    end
    // Count consecutive fetch denials; any idle or granted fetch cycle clears.
    if (bus.if_req && !if_win) begin
      starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
    end
  end

  assign bus.if_gnt      = if_win;
  assign bus.dm_gnt      = dm_win;
  assign bus.ram_re      = if_win | (dm_win & ~bus.dm_we);
  assign bus.ram_we      = dm_win & bus.dm_we;
  assign bus.ram_address = addr_mux;
  assign bus.ram_wdata   = wdata_mux;

  assign bus.if_rvalid = (owner == OWN_IF);
  assign bus.dm_rvalid = (owner == OWN_DM);
  assign bus.if_rdata  = (owner == OWN_IF) ? bus.ram_rdata : '0;
  assign bus.dm_rdata  = (owner == OWN_DM) ? bus.ram_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 31;
  localparam int SL = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if #(.DATA_WIDTH(DW), .RAM_WIDTH(AW)) bus ();

  mem_arbiter #(
    .DATA_WIDTH  (DW),
    .RAM_WIDTH   (AW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: denial counter and the pending return owner (0 none, 1 if, 2 dm).
  int            m_starve;
  int            m_ret;
  logic          e_if_gnt, e_dm_gnt, e_re, e_we, e_if_rv, e_dm_rv, e_wd_chk;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_if_rd, e_dm_rd;

  function automatic void model_eval();
    e_if_gnt = 1'b0; e_dm_gnt = 1'b0; e_re = 1'b0; e_we = 1'b0;
    e_addr = '0; e_wdata = '0; e_wd_chk = 1'b1;
    if (rst_n) begin
      e_if_gnt = bus.if_req && (!bus.dm_req || m_starve == SL);
      e_dm_gnt = bus.dm_req && !e_if_gnt;
    end
    if (e_if_gnt) begin
      e_addr = bus.if_addr; e_re = 1'b1; e_wd_chk = 1'b0;
    end else if (e_dm_gnt) begin
      e_addr = bus.dm_addr;
      if (bus.dm_we) begin e_we = 1'b1; e_wdata = bus.dm_wdata; end
      else begin e_re = 1'b1; e_wd_chk = 1'b0; end
    end
    e_if_rv = rst_n && m_ret == 1;
    e_dm_rv = rst_n && m_ret == 2;
    e_if_rd = e_if_rv ? bus.ram_rdata : '0;
    e_dm_rd = e_dm_rv ? bus.ram_rdata : '0;
  endfunction

  function automatic void model_clock();
    if (!rst_n) begin
      m_starve = 0; m_ret = 0;
      return;
    end
    m_ret = e_if_gnt ? 1 : (e_dm_gnt && !bus.dm_we) ? 2 : 0;
    if (bus.if_req && !e_if_gnt) m_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
    else m_starve = 0;
  endfunction

  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dwe,
                       input logic [AW-1:0] da, input logic [DW-1:0] dwd, input logic [DW-1:0] rd);
    bus.if_req = ir; bus.if_addr = ia;
    bus.dm_req = dr; bus.dm_we = dwe; bus.dm_addr = da; bus.dm_wdata = dwd;
    bus.ram_rdata = rd;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [164:0] act;
    rst_n = 1'b0;
    m_starve = 0; m_ret = 0;
    drive(1'b1, AW'('h5), 1'b1, 1'b1, AW'('h7), 32'hAAAA_5555, 32'h1);
    act = {bus.if_gnt, bus.dm_gnt, bus.ram_re, bus.ram_we, bus.ram_address, bus.ram_wdata,
           bus.if_rvalid, bus.dm_rvalid, bus.if_rdata, bus.dm_rdata};
    checks++;
    if (act !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", act);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    tick();
  endtask

  task automatic test_fetch();
    logic [34:0] g;
    logic [65:0] r;
    drive(1'b1, AW'('h10), 1'b0, 1'b0, '0, '0, DW'($urandom));
    g = {bus.if_gnt, bus.dm_gnt, bus.ram_re, bus.ram_we, bus.ram_address};
    checks++;
    if (g !== {1'b1, 1'b0, 1'b1, 1'b0, AW'('h10)}) begin
      errors++; $display("FAIL fetch_grant: got %h want %h", g, {1'b1, 1'b0, 1'b1, 1'b0, AW'('h10)});
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 32'hDEAD_BEEF);
    r = {bus.if_rvalid, bus.dm_rvalid, bus.if_rdata, bus.dm_rdata};
    checks++;
    if (r !== {1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0}) begin
      errors++; $display("FAIL fetch_return: got %h want %h", r, {1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0});
    end
    tick();
  endtask

  task automatic test_store();
    logic [66:0] g;
    drive(1'b0, '0, 1'b1, 1'b1, AW'('h20), 32'h1234_5678, DW'($urandom));
    g = {bus.dm_gnt, bus.if_gnt, bus.ram_we, bus.ram_re, bus.ram_address, bus.ram_wdata};
    checks++;
    if (g !== {1'b1, 1'b0, 1'b1, 1'b0, AW'('h20), 32'h1234_5678}) begin
      errors++; $display("FAIL store_grant: got %h want %h", g,
                         {1'b1, 1'b0, 1'b1, 1'b0, AW'('h20), 32'h1234_5678});
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, DW'($urandom));
    checks++;
    if ({bus.if_rvalid, bus.dm_rvalid} !== 2'b00) begin
      errors++; $display("FAIL store_no_rvalid: got %b want 00", {bus.if_rvalid, bus.dm_rvalid});
    end
    tick();
  endtask

  task automatic test_starvation();
    logic [7:0] if_pat;
    if_pat = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, AW'($urandom), 1'b1, 1'b0, AW'($urandom), DW'($urandom), DW'($urandom));
      checks++;
      if ({bus.if_gnt, bus.dm_gnt} !== {if_pat[i], ~if_pat[i]}) begin
        errors++; $display("FAIL starve_grant[%0d]: got %b want %b", i,
                           {bus.if_gnt, bus.dm_gnt}, {if_pat[i], ~if_pat[i]});
      end
      checks++;
      if ({bus.if_rvalid, bus.dm_rvalid, bus.if_rdata, bus.dm_rdata} !== {e_if_rv, e_dm_rv, e_if_rd, e_dm_rd}) begin
        errors++; $display("FAIL starve_return[%0d]: got %h want %h", i,
                           {bus.if_rvalid, bus.dm_rvalid, bus.if_rdata, bus.dm_rdata},
                           {e_if_rv, e_dm_rv, e_if_rd, e_dm_rd});
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, DW'($urandom));
    checks++;
    if ({bus.if_rvalid, bus.dm_rvalid} !== 2'b10) begin
      errors++; $display("FAIL starve_last_return: got %b want 10", {bus.if_rvalid, bus.dm_rvalid});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic          ifr;
    logic [DW-1:0] rd;
    logic [65:0]   r;
    for (int i = 0; i < 7; i++) begin
      ifr = (i % 2) == 1;
      rd  = DW'($urandom);
      if (i < 6) drive(ifr, AW'($urandom), ~ifr, 1'b0, AW'($urandom), DW'($urandom), rd);
      else drive(1'b0, '0, 1'b0, 1'b0, '0, '0, rd);
      if (i < 6) begin
        checks++;
        if ({bus.if_gnt, bus.dm_gnt, bus.ram_re} !== {ifr, ~ifr, 1'b1}) begin
          errors++; $display("FAIL b2b_grant[%0d]: got %b want %b", i,
                             {bus.if_gnt, bus.dm_gnt, bus.ram_re}, {ifr, ~ifr, 1'b1});
        end
      end
      if (i > 0) begin
        // Previous cycle granted the other requester.
        r = {bus.if_rvalid, bus.dm_rvalid, bus.if_rdata, bus.dm_rdata};
        checks++;
        if (r !== {~ifr, ifr, (ifr ? DW'(0) : rd), (ifr ? rd : DW'(0))}) begin
          errors++; $display("FAIL b2b_return[%0d]: got %h want %h", i, r,
                             {~ifr, ifr, (ifr ? DW'(0) : rd), (ifr ? rd : DW'(0))});
        end
      end
      tick();
    end
  endtask

  task automatic test_idle();
    logic [66:0] g;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, AW'($urandom), 1'b0, 1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
      g = {bus.if_gnt, bus.dm_gnt, bus.ram_re, bus.ram_we, bus.ram_address, bus.ram_wdata};
      checks++;
      if (g !== '0) begin
        errors++; $display("FAIL idle[%0d]: got %h want 0", i, g);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic          ir = 1'b0, dr = 1'b0, dwe = 1'b0;
    logic [AW-1:0] ia = '0, da = '0;
    logic [DW-1:0] dwd = '0;
    logic [100:0]  act, exp;
    for (int n = 0; n < 400; n++) begin
      // Ungranted requests are held unchanged until accepted.
      if (!ir) begin ir = ($urandom % 3) != 0; ia = AW'($urandom); end
      if (!dr) begin
        dr = ($urandom % 3) != 0; dwe = 1'($urandom); da = AW'($urandom); dwd = DW'($urandom);
      end
      drive(ir, ia, dr, dwe, da, dwd, DW'($urandom));
      act = {bus.if_gnt, bus.dm_gnt, bus.ram_re, bus.ram_we, bus.ram_address,
             bus.if_rvalid, bus.dm_rvalid, bus.if_rdata, bus.dm_rdata};
      exp = {e_if_gnt, e_dm_gnt, e_re, e_we, e_addr, e_if_rv, e_dm_rv, e_if_rd, e_dm_rd};
      checks++;
      if (act !== exp) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", n, act, exp);
      end
      if (e_wd_chk) begin
        checks++;
        if (bus.ram_wdata !== e_wdata) begin
          errors++; $display("FAIL random_wdata[%0d]: got %h want %h", n, bus.ram_wdata, e_wdata);
        end
      end
      if (e_if_gnt) ir = 1'b0;
      if (e_dm_gnt) dr = 1'b0;
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    tick();
  endtask

  task automatic test_reset_mid();
    logic [164:0] act;
    drive(1'b0, '0, 1'b1, 1'b0, AW'('h33), '0, 32'hCAFE_F00D);
    checks++;
    if ({bus.dm_gnt, bus.ram_re} !== 2'b11) begin
      errors++; $display("FAIL rstmid_grant: got %b want 11", {bus.dm_gnt, bus.ram_re});
    end
    @(posedge clk);
    model_clock();
    #2;
    rst_n = 1'b0;
    #1;
    model_clock();
    act = {bus.if_gnt, bus.dm_gnt, bus.ram_re, bus.ram_we, bus.ram_address, bus.ram_wdata,
           bus.if_rvalid, bus.dm_rvalid, bus.if_rdata, bus.dm_rdata};
    checks++;
    if (act !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got %h want 0", act);
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    drive(1'b1, AW'('h44), 1'b0, 1'b0, '0, '0, 32'h5555_AAAA);
    checks++;
    if ({bus.if_gnt, bus.dm_rvalid, bus.if_rvalid} !== 3'b100) begin
      errors++; $display("FAIL rstmid_release: got %b want 100", {bus.if_gnt, bus.dm_rvalid, bus.if_rvalid});
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 32'h0BAD_F00D);
    checks++;
    if ({bus.if_rvalid, bus.dm_rvalid, bus.if_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL rstmid_first_return: got %h want %h",
                         {bus.if_rvalid, bus.dm_rvalid, bus.if_rdata}, {2'b10, 32'h0BAD_F00D});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_starvation();
    test_back_to_back();
    test_idle();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
